// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// Holds the FSM state encoding and packet header decode.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } sched_state_e;

    localparam int HDR_W     = 8;
    localparam int PKT_MAX_W = 256;

    // Destination ID lives in the top HDR_W bits of the packet.
    function automatic logic [HDR_W-1:0] hdr_dst(
        input logic [PKT_MAX_W-1:0] pkt,
        input int                   pkt_w
    );
        return pkt[pkt_w-1 -: HDR_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`.
// valid is low when no request is present.
module rr_arbiter #(
    parameter int drvrs = 4
) (
    input  logic [drvrs-1:0]         req,
    input  logic [$clog2(drvrs)-1:0] last,
    output logic [$clog2(drvrs)-1:0] grant,
    output logic                     valid
);

    localparam int IDW = $clog2(drvrs);

    // Scan last+1 .. last+drvrs (mod drvrs); first hit wins.
    always_comb begin : scan
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= drvrs; i++) begin
            idx = (int'(last) + i) % drvrs;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin transfer scheduler for a shared broadcast bus.
// Optional macro BUS_BROADCAST_EN enables broadcast delivery.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 32,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                drop_cnt
);

    localparam int IDW = $clog2(drvrs);

`ifdef BUS_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    sched_state_e state, state_n;

    logic [IDW-1:0]     last, last_n;
    logic [IDW-1:0]     grant_n, arb_grant;
    logic               arb_valid;
    logic [drvrs-1:0]   pop_n, push_n;
    logic [pckg_sz-1:0] bus_n, pkt_sel;
    logic [15:0]        drop_n;
    logic               busy_n;
    logic [HDR_W-1:0]   dst;
    logic               uni_ok, bcast_ok;

    rr_arbiter #(
        .drvrs (drvrs)
    ) u_arb (
        .req   (pndng),
        .last  (last),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Head-of-FIFO word of the granted driver and its destination.
    always_comb begin
        pkt_sel  = D_pop[int'(grant_id)*pckg_sz +: pckg_sz];
        dst      = hdr_dst(PKT_MAX_W'(pkt_sel), pckg_sz);
        uni_ok   = (int'(dst) < drvrs) &&
                   (int'(dst) != int'(grant_id));
        bcast_ok = BCAST_EN && (dst == broadcast);
    end

    // Next-state and next-output logic; strobes are one cycle wide.
    always_comb begin
        state_n = state;
        grant_n = grant_id;
        last_n  = last;
        pop_n   = '0;
        push_n  = '0;
        bus_n   = D_push;
        drop_n  = drop_cnt;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_n          = arb_grant;
                    pop_n[arb_grant] = 1'b1;
                    state_n          = POP;
                end
            end
            POP: begin
                bus_n   = pkt_sel;
                last_n  = grant_id;
                state_n = PUSH;
                if (uni_ok) begin
                    push_n[dst[IDW-1:0]] = 1'b1;
                end else if (bcast_ok) begin
                    push_n = ~(drvrs'(1) << grant_id);
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_n = drop_cnt + 16'd1;
                end
            end
            PUSH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= IDW'(drvrs - 1);
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            last     <= last_n;
            pop      <= pop_n;
            push     <= push_n;
            D_push   <= bus_n;
            busy     <= busy_n;
            drop_cnt <= drop_n;
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler.
// Per-driver packet queues feed the DUT; a transfer model predicts outputs.
`timescale 1ns/1ps
module tb_bus_rr_scheduler;

    localparam int N = 4;
    localparam int W = 32;

`ifdef BUS_BROADCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [W-1:0]   D_push;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    drop_cnt;

    always #5 clk = ~clk;

    bus_rr_scheduler #(
        .drvrs     (N),
        .pckg_sz   (W),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q [N][$];

    int           m_phase;
    int           m_grant;
    int           m_last;
    int           m_drop;
    int           cyc;
    logic [N-1:0] e_pop;
    logic [N-1:0] e_push;
    logic [W-1:0] e_dpush;
    logic         e_busy;
    logic [N-1:0] seen_push;
    int           g_drv[$];
    int           g_cyc[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_grant = 0;
        m_last  = N - 1;
        m_drop  = 0;
        e_pop   = '0;
        e_push  = '0;
        e_dpush = '0;
        e_busy  = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (q[i].size() != 0);
            D_pop[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    // Predict outputs after the next rising edge from current inputs.
    task automatic model_step();
        logic [W-1:0] pkt;
        int           dst;
        int           c;
        bit           found;
        case (m_phase)
            0: begin
                e_pop  = '0;
                e_push = '0;
                e_busy = 1'b0;
                found  = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && pndng[c]) begin
                        found   = 1'b1;
                        m_grant = c;
                    end
                end
                if (found) begin
                    e_pop   = N'(1) << m_grant;
                    e_busy  = 1'b1;
                    m_phase = 1;
                    g_drv.push_back(m_grant);
                    g_cyc.push_back(cyc);
                end
            end
            1: begin
                pkt     = D_pop[m_grant*W +: W];
                dst     = int'(pkt[W-1 -: 8]);
                m_last  = m_grant;
                e_pop   = '0;
                e_dpush = pkt;
                e_busy  = 1'b1;
                m_phase = 2;
                if (dst < N && dst != m_grant) begin
                    e_push = N'(1) << dst;
                end else if (BC && dst == 255) begin
                    e_push = ~(N'(1) << m_grant);
                end else begin
                    e_push = '0;
                    if (m_drop < 65535) m_drop++;
                end
            end
            default: begin
                e_push  = '0;
                e_busy  = 1'b0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic start();
        drive();
        model_step();
    endtask

    // One clock: compare at the falling edge, then advance environment.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        chk("pop", 64'(pop), 64'(e_pop));
        chk("push", 64'(push), 64'(e_push));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (e_push != 0) chk("D_push", 64'(D_push), 64'(e_dpush));
        seen_push |= push;
        if (m_phase == 2) void'(q[m_grant].pop_front());
        drive();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        pndng = '0;
        D_pop = '0;
        model_reset();
        seen_push = '0;
        @(negedge clk);
        chk("rst_pop", 64'(pop), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
    endtask

    function automatic int q_total();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    initial begin
        reset     = 1'b0;
        pndng     = '0;
        D_pop     = '0;
        cyc       = 0;
        seen_push = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_pop", 64'(pop), 64'h0);
        chk("reset_push", 64'(push), 64'h0);
        chk("reset_dpush", 64'(D_push), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_grant", 64'(grant_id), 64'h0);
        chk("reset_drop", 64'(drop_cnt), 64'h0);
        reset = 1'b1;

        // Single unicast transfer 0 -> 2.
        q[0].push_back(32'h0200ABCD);
        start();
        cycle();
        chk("t1_pop", 64'(pop), 64'h1);
        chk("t1_push_lo", 64'(push), 64'h0);
        cycle();
        chk("t1_push", 64'(push), 64'h4);
        chk("t1_dpush", 64'(D_push), 64'h0200ABCD);
        chk("t1_pop_lo", 64'(pop), 64'h0);
        repeat (3) cycle();
        chk("t1_idle", 64'(busy), 64'h0);

        // Continuous load: every driver sends 3 packets to (i+1)%4.
        do_reset();
        g_drv.delete();
        g_cyc.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 3; j++)
                q[i].push_back({8'((i + 1) % N), 8'(j),
                                16'(16'hA000 + i)});
        start();
        repeat (40) cycle();
        checks++;
        if (g_drv.size() < 5) begin
            failures++;
            $display("FAIL t2_grants actual=%0d required=12",
                     g_drv.size());
        end else begin
            chk("t2_g0", 64'(g_drv[0]), 64'd0);
            chk("t2_g1", 64'(g_drv[1]), 64'd1);
            chk("t2_g2", 64'(g_drv[2]), 64'd2);
            chk("t2_g3", 64'(g_drv[3]), 64'd3);
            chk("t2_g4", 64'(g_drv[4]), 64'd0);
            chk("t2_period", 64'(g_cyc[4] - g_cyc[0]), 64'd12);
        end
        chk("t2_drained", 64'(q_total()), 64'd0);
        chk("t2_drop", 64'(drop_cnt), 64'd0);

        // Broadcast header from driver 2.
        do_reset();
        q[2].push_back(32'hFF001234);
        start();
        repeat (5) cycle();
        chk("t3_push", 64'(seen_push), BC ? 64'hB : 64'h0);
        chk("t3_drop", 64'(drop_cnt), BC ? 64'd0 : 64'd1);

        // Self-addressed and out-of-range destinations.
        do_reset();
        q[1].push_back(32'h01000055);
        q[1].push_back(32'h07000066);
        start();
        repeat (8) cycle();
        chk("t4_push", 64'(seen_push), 64'h0);
        chk("t4_drop", 64'(drop_cnt), 64'd2);

        // Reset during the POP cycle, then resume.
        do_reset();
        q[1].push_back(32'h030000AA);
        q[3].push_back(32'h010000BB);
        start();
        cycle();
        chk("t5_pop", 64'(pop), 64'h2);
        #2 reset = 1'b0;
        #1;
        chk("t5_abort_pop", 64'(pop), 64'h0);
        chk("t5_abort_busy", 64'(busy), 64'h0);
        chk("t5_abort_grant", 64'(grant_id), 64'h0);
        chk("t5_abort_push", 64'(push), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        start();
        cycle();
        chk("t5_regrant", 64'(pop), 64'h2);
        repeat (8) cycle();
        chk("t5_drained", 64'(q_total()), 64'd0);
        chk("t5_push", 64'(seen_push), 64'hA);
        chk("t5_drop", 64'(drop_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
